// File: rtl/serial_write_queue.sv
// Queued serial write buffer: parallel words enter a FIFO and leave one bit per
// write_sig strobe, back-to-back with no idle bit between consecutive words.
module serial_write_queue #(
   parameter int   WORD_SIZE  = 8,
   parameter int   FIFO_DEPTH = 4,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b1,
   localparam int  CW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WORD_SIZE-1:0] data_in,
   output logic                 full,
   output logic                 empty,
   output logic [CW-1:0]        count,
   input  logic                 write_sig,
   output logic                 data_out,
   output logic                 busy,
   output logic                 word_done,
   output logic                 underrun,
   input  logic                 clr_underrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(WORD_SIZE);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]          wrPtr_q, rdPtr_q, used;
   logic [0:0]           state_q, state_d;
   logic [WORD_SIZE-1:0] shift_q, shift_d;
   logic [BW-1:0]        bitCnt_q, bitCnt_d;
   logic                 dataOut_q, dataOut_d;
   logic                 wordDone_q, wordDone_d;
   logic                 underrun_q, underrun_d;
   logic                 doPush, doPop, lastBit, strobeLast;
   logic [WORD_SIZE-1:0] headWord;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign used     = wrPtr_q - rdPtr_q;
   assign empty    = (wrPtr_q == rdPtr_q);
   assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign count    = used;
   assign headWord = mem_q[rdPtr_q[AW-1:0]];

   assign doPush     = push && !full;
   assign lastBit    = (bitCnt_q == BW'(WORD_SIZE - 1));
   assign strobeLast = (state_q == ST_SHIFT) && write_sig && lastBit;
   assign doPop      = !empty && ((state_q == ST_IDLE) || strobeLast);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitCnt_d = bitCnt_q;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               shift_d  = headWord;
               bitCnt_d = '0;
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (write_sig) begin
               if (lastBit) begin
                  bitCnt_d = '0;
                  if (!empty) shift_d = headWord;
                  else        state_d = ST_IDLE;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
                  shift_d  = MSB_FIRST ? {shift_q[WORD_SIZE-2:0], 1'b0}
                                       : {1'b0, shift_q[WORD_SIZE-1:1]};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The output bit is computed from the next shifter value so data_out is a flop.
      if (state_d == ST_SHIFT) dataOut_d = MSB_FIRST ? shift_d[WORD_SIZE-1] : shift_d[0];
      else                     dataOut_d = IDLE_LEVEL;

      wordDone_d = strobeLast;
      if (clr_underrun) underrun_d = 1'b0;
      else              underrun_d = underrun_q || (write_sig && (state_q == ST_IDLE));
   end

   always_ff @(posedge sys_clk) begin
      if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_in;
   end

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bitCnt_q   <= '0;
         dataOut_q  <= IDLE_LEVEL;
         wordDone_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         state_q    <= state_d;
         shift_q    <= shift_d;
         bitCnt_q   <= bitCnt_d;
         dataOut_q  <= dataOut_d;
         wordDone_q <= wordDone_d;
         underrun_q <= underrun_d;
      end
   end

   assign data_out  = dataOut_q;
   assign busy      = (state_q == ST_SHIFT);
   assign word_done = wordDone_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_serial_write_queue.sv
// Scoreboard bench: two instances (MSB-first/idle-high and LSB-first/idle-low)
// share one input stream; a negedge monitor checks every consumed bit.
`timescale 1ns/100ps
module tb_serial_write_queue;

   localparam int WS    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          sysClk = 1'b0;
   logic          rst = 1'b0;
   logic          push = 1'b0;
   logic [WS-1:0] dataIn = '0;
   logic          writeSig = 1'b0;
   logic          clrUnderrun = 1'b0;

   logic          fullA, emptyA, dataOutA, busyA, wordDoneA, underrunA;
   logic [CW-1:0] countA;
   logic          fullB, emptyB, dataOutB, busyB, wordDoneB, underrunB;
   logic [CW-1:0] countB;

   logic [WS-1:0] expWords[$];
   int            bitIdx = 0;
   logic          expectDone = 1'b0;
   int            checks = 0;
   int            errors = 0;

   serial_write_queue #(.WORD_SIZE(WS), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dutA (
      .sys_clk(sysClk), .rst(rst), .push(push), .data_in(dataIn),
      .full(fullA), .empty(emptyA), .count(countA), .write_sig(writeSig),
      .data_out(dataOutA), .busy(busyA), .word_done(wordDoneA),
      .underrun(underrunA), .clr_underrun(clrUnderrun));

   serial_write_queue #(.WORD_SIZE(WS), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dutB (
      .sys_clk(sysClk), .rst(rst), .push(push), .data_in(dataIn),
      .full(fullB), .empty(emptyB), .count(countB), .write_sig(writeSig),
      .data_out(dataOutB), .busy(busyB), .word_done(wordDoneB),
      .underrun(underrunB), .clr_underrun(clrUnderrun));

   always #5 sysClk = ~sysClk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs; accepted words enter the scoreboard.
   task automatic applyStimulus(input logic doPush, input logic [WS-1:0] word,
                                input logic accepted, input logic doStrobe, input logic doClr);
      push        = doPush;
      dataIn      = word;
      writeSig    = doStrobe;
      clrUnderrun = doClr;
      if (doPush && accepted) expWords.push_back(word);
      @(posedge sysClk);
      #1;
      push        = 1'b0;
      writeSig    = 1'b0;
      clrUnderrun = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic strobes(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
         idleCycles(gap - 1);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_dataOutA"}, dataOutA, 1'b1);
      checkOutput({tag, "_dataOutB"}, dataOutB, 1'b0);
      checkOutput({tag, "_busy"}, busyA, 1'b0);
      checkOutput({tag, "_empty"}, emptyA, 1'b1);
   endtask

   // Word_done is compared against the flag raised by the previous negedge's last-bit consumption.
   always @(negedge sysClk) begin
      logic [WS-1:0] w;
      logic          doneNow;
      if (rst) begin
         checkOutput("wordDoneA", wordDoneA, expectDone);
         checkOutput("wordDoneB", wordDoneB, expectDone);
         doneNow = 1'b0;
         if (writeSig && busyA) begin
            if (expWords.size() == 0) begin
               checkOutput("unexpectedBit", 1, 0);
            end else begin
               w = expWords[0];
               checkOutput("bitMsbFirst", dataOutA, w[WS-1-bitIdx]);
               checkOutput("bitLsbFirst", dataOutB, w[bitIdx]);
               bitIdx++;
               if (bitIdx == WS) begin
                  void'(expWords.pop_front());
                  bitIdx  = 0;
                  doneNow = 1'b1;
               end
            end
         end
         expectDone = doneNow;
      end
   end

   initial begin
      int cooldown;
      logic doP, doS;
      logic [WS-1:0] w;

      #12;
      checkOutput("rst_dataOutA", dataOutA, 1'b1);
      checkOutput("rst_dataOutB", dataOutB, 1'b0);
      checkOutput("rst_full", fullA, 1'b0);
      checkOutput("rst_empty", emptyA, 1'b1);
      checkOutput("rst_count", countA, 0);
      checkOutput("rst_busy", busyA, 1'b0);
      checkOutput("rst_wordDone", wordDoneA, 1'b0);
      checkOutput("rst_underrun", underrunA, 1'b0);
      @(posedge sysClk);
      #1 rst = 1'b1;
      idleCycles(2);

      $display("[TB] single word 0x9C");
      applyStimulus(1'b1, 8'h9C, 1'b1, 1'b0, 1'b0);
      checkOutput("push1_empty", emptyA, 1'b0);
      checkOutput("push1_count", countA, 1);
      checkOutput("push1_busy", busyA, 1'b0);
      idleCycles(1);
      checkOutput("load_busy", busyA, 1'b1);
      checkOutput("load_count", countA, 0);
      checkOutput("load_firstBitA", dataOutA, 1'b1);
      checkOutput("load_firstBitB", dataOutB, 1'b0);
      strobes(8, 8);
      checkIdleOutputs("single_after");
      checkOutput("single_underrun", underrunA, 1'b0);

      $display("[TB] back-to-back 0x9C 0xE4");
      applyStimulus(1'b1, 8'h9C, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hE4, 1'b1, 1'b0, 1'b0);
      checkOutput("b2b_count", countA, 1);
      checkOutput("b2b_busy", busyA, 1'b1);
      strobes(8, 4);
      checkOutput("b2b_secondLoaded_count", countA, 0);
      checkOutput("b2b_secondLoaded_busy", busyA, 1'b1);
      checkOutput("b2b_secondFirstBit", dataOutA, 1'b1);
      strobes(8, 4);
      checkIdleOutputs("b2b_after");

      $display("[TB] fill FIFO");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, WS'(8'h11 * (i + 1)), 1'b1, 1'b0, 1'b0);
      checkOutput("fill_full", fullA, 1'b1);
      checkOutput("fill_count", countA, 4);
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      checkOutput("fill_ignored_count", countA, 4);
      checkOutput("fill_ignored_full", fullA, 1'b1);
      strobes(40, 3);
      checkIdleOutputs("fill_after");
      checkOutput("fill_scoreboardEmpty", expWords.size(), 0);

      $display("[TB] reset mid-word");
      applyStimulus(1'b1, 8'hE4, 1'b1, 1'b0, 1'b0);
      idleCycles(1);
      strobes(3, 3);
      #2 rst = 1'b0;
      #0.5;
      checkOutput("midrst_dataOutA", dataOutA, 1'b1);
      checkOutput("midrst_dataOutB", dataOutB, 1'b0);
      checkOutput("midrst_busy", busyA, 1'b0);
      checkOutput("midrst_empty", emptyA, 1'b1);
      checkOutput("midrst_count", countA, 0);
      checkOutput("midrst_full", fullA, 1'b0);
      expWords.delete();
      bitIdx = 0;
      expectDone = 1'b0;
      #0.5 rst = 1'b1;
      idleCycles(1);
      applyStimulus(1'b1, 8'hE4, 1'b1, 1'b0, 1'b0);
      idleCycles(1);
      strobes(8, 3);
      checkIdleOutputs("midrst_after");

      $display("[TB] underrun");
      checkOutput("ur_before", underrunA, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("ur_set", underrunA, 1'b1);
      checkOutput("ur_dataOutA", dataOutA, 1'b1);
      checkOutput("ur_dataOutB", dataOutB, 1'b0);
      idleCycles(2);
      checkOutput("ur_sticky", underrunA, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
      checkOutput("ur_cleared", underrunA, 1'b0);
      idleCycles(1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
      checkOutput("ur_clrPriority", underrunA, 1'b0);
      checkOutput("ur_clrPriorityB", underrunB, 1'b0);

      $display("[TB] random traffic");
      cooldown = 0;
      for (int i = 0; i < 600; i++) begin
         doP = ($urandom_range(0, 2) == 0) && (expWords.size() < DEPTH);
         doS = (cooldown == 0) && ($urandom_range(0, 1) == 1);
         w   = WS'($urandom);
         applyStimulus(doP, w, 1'b1, doS, 1'b0);
         if (doS) cooldown = $urandom_range(1, 3);
         else if (cooldown > 0) cooldown--;
      end
      for (int i = 0; i < 400 && expWords.size() != 0; i++) strobes(1, 2);
      checkOutput("drain_scoreboardEmpty", expWords.size(), 0);
      idleCycles(2);
      checkIdleOutputs("drain_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_write_queue.md
# serial_write_queue

Queued, parametrised successor to the single-word serial write buffer. Accepts parallel words into an internal FIFO and shifts them out one bit per external `write_sig` strobe, with configurable word width, queue depth, bit order and idle line level. Back-to-back words go out with no gap between them. Sits between protocol engines and the MITM output pins, with `write_sig` coming from an edge detector on the target's bit clock.

## Interface

Parameters:
- `WORD_SIZE`, 8: bits per word, at least 2.
- `FIFO_DEPTH`, 4: number of queued words; power of two, at least 2.
- `MSB_FIRST`, 1: 1 shifts out the MSB first, 0 shifts out the LSB first.
- `IDLE_LEVEL`, 1'b1: value driven on `data_out` when no word is loaded.

Ports:
- `sys_clk`  in  1  system clock; every register uses its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `push`  in  1  enqueue `data_in` at this edge when `full`=0.
- `data_in`  in  WORD_SIZE  word to enqueue.
- `full`  out  1  FIFO holds `FIFO_DEPTH` words.
- `empty`  out  1  FIFO holds 0 words.
- `count`  out  $clog2(FIFO_DEPTH+1)  number of words in the FIFO; excludes the word in the shifter.
- `write_sig`  in  1  one-cycle strobe that advances the output by one bit.
- `data_out`  out  1  serial output bit, registered.
- `busy`  out  1  a word is loaded in the shifter.
- `word_done`  out  1  one-cycle pulse after the last bit of a word is consumed.
- `underrun`  out  1  sticky flag: a strobe arrived with nothing loaded.
- `clr_underrun`  in  1  synchronous clear of `underrun`.

## Operation

- FIFO: circular buffer; read and write pointers are one bit wider than the address to tell full from empty.
  - `push` while `full`=1 is ignored, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: `count` is unchanged.
- FSM states: IDLE and SHIFT.
- IDLE:
  - `data_out`=IDLE_LEVEL, `busy`=0.
  - If `empty`=0: pop the head word into the shifter, set bit counter to 0, go to SHIFT.
  - `write_sig` in IDLE (including the load cycle) does not shift; it sets `underrun`.
- SHIFT:
  - `data_out` shows the current bit: shifter MSB if `MSB_FIRST`=1, else shifter LSB.
  - Each `write_sig` shifts by one and increments the counter.
  - A `write_sig` with counter = WORD_SIZE-1 is the last bit:
    - assert `word_done` for the next cycle;
    - if `empty`=0, pop and load the next word in the same edge, stay in SHIFT, counter to 0;
    - otherwise go to IDLE.
- `clr_underrun` has priority over a set in the same cycle.
- Reset, asynchronous and at any time, including mid-word:
  - FIFO emptied, pointers 0, FSM to IDLE, counter 0.
  - Outputs: `data_out`=IDLE_LEVEL, `full`=0, `empty`=1, `count`=0, `busy`=0, `word_done`=0, `underrun`=0.
  - After reset release, behaviour is identical to power-up.

## Timing

- Push at edge N into an empty FIFO while IDLE:
  - `empty`=0 after edge N.
  - Load at edge N+1; first bit valid on `data_out` and `busy`=1 after N+1.
  - Latency from push to first bit: 2 cycles.
- Strobe at edge M: next bit on `data_out` after edge M.
- Last strobe at edge M:
  - `word_done`=1 during cycle M+1.
  - If a word was queued, its first bit is shown after M, with no idle bit between words.
  - If not, `data_out` returns to IDLE_LEVEL after M.
- `write_sig` strobes must be at least 2 `sys_clk` cycles apart; behaviour is undefined for closer strobes.
- `full`, `empty` and `count` are registered and update one edge after the push or pop.

## Test plan

- WORD_SIZE=8, MSB_FIRST=1: push 0x9C, then 8 strobes at 8-cycle spacing -> `data_out` = 1,0,0,1,1,1,0,0; `word_done` pulses once after the 8th strobe; `data_out` returns to 1 and `busy`=0.
- Push 0x9C and 0xE4 back-to-back, then 16 strobes -> stream 10011100 11100100 with no idle bit; `word_done` pulses after strobes 8 and 16; `count` goes 1→0 when the second word loads.
- FIFO_DEPTH=4: push 5 words while IDLE with no strobes -> first word loads, the remaining 4 fill the FIFO; `full`=1, `count`=4; a further push is ignored; 40 strobes return exactly the first 5 words in order.
- Push 0xE4, give 3 strobes, pulse `rst` low for 1 ns between edges -> all outputs at reset values immediately; then push 0xE4 with 8 strobes -> clean 11100100.
- Strobe with FIFO empty -> `underrun`=1, `data_out` stays IDLE_LEVEL; `clr_underrun` for 1 cycle -> `underrun`=0; `clr_underrun` and a strobe in the same cycle -> `underrun` stays 0.
- MSB_FIRST=0, IDLE_LEVEL=0: push 0x9C, then 8 strobes -> `data_out` = 0,0,1,1,1,0,0,1, and `data_out`=0 when idle.
